// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    function automatic int rf_addr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int AW_DEF = rf_addr_width(DEPTH_DEF);

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

    typedef struct packed {
        logic                en;
        logic [AW_DEF-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
    } rf_wr_port_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] data;
        logic                pend;
    } rf_rd_port_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module rf_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NW-1:0]          we,
    input  logic [NW-1:0][AW-1:0]  waddr,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    input  logic [NR-1:0][AW-1:0]  raddr,
    output logic [NR-1:0]          rpend
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;
    logic [NR-1:0]    wr_hit;

    // Order encodes priority: flush, then writeback clears, then a new issue wins.
    always_comb begin
        pending_nxt = flush ? '0 : pending;
        for (int j = 0; j < NW; j++) begin
            if (we[j]) pending_nxt[waddr[j]] = 1'b0;
        end
        if (iss_valid) pending_nxt[iss_addr] = 1'b1;
        if (ZERO_REG) pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    always_comb begin
        wr_hit = '0;
        rpend  = '0;
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && waddr[j] == raddr[i]) wr_hit[i] = 1'b1;
            end
            rpend[i] = pending[raddr[i]] && !wr_hit[i];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset sequential clear, write bypass and
// a pending-write scoreboard for the issue stage.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = rf_addr_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NW-1:0]           we,
    input  logic [NW-1:0][AW-1:0]   waddr,
    input  logic [NW-1:0][XLEN-1:0] wdata,
    input  logic [NR-1:0][AW-1:0]   raddr,
    output logic [NR-1:0][XLEN-1:0] rdata,
    output logic [NR-1:0]           rpend,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_addr,
    input  logic                    flush,
    output logic                    ready
);

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    rf_state_t       state;
    logic [AW:0]     cnt;
    logic [XLEN-1:0] mem [DEPTH];
    logic [NW-1:0]   we_run;
    logic [NR-1:0]   rpend_raw;

    assign we_run = (state == RF_RUN) ? we : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                RF_INIT: begin
                    cnt <= cnt + (AW+1)'(1);
                    if (cnt == CNT_LAST) begin
                        state <= RF_RUN;
                        ready <= 1'b1;
                    end
                end
                RF_RUN:  ;
                default: state <= RF_INIT;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the INIT sweep clears it so it can map to RAM.
    always_ff @(posedge clk) begin
        if (state == RF_INIT) begin
            mem[cnt[AW-1:0]] <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && !(ZERO_REG && waddr[j] == '0)) mem[waddr[j]] <= wdata[j];
            end
        end
    end

    // NOTE: blocking assignments here let the last matching port override, so the highest index wins.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NR; i++) begin
            rdata[i] = mem[raddr[i]];
            for (int j = 0; j < NW; j++) begin
                if (we_run[j] && waddr[j] == raddr[i]) rdata[i] = wdata[j];
            end
            if (!ready || (ZERO_REG && raddr[i] == '0)) rdata[i] = '0;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NR       (NR),
        .NW       (NW),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we_run),
        .waddr     (waddr),
        .iss_valid (iss_valid && state == RF_RUN),
        .iss_addr  (iss_addr),
        .flush     (flush && state == RF_RUN),
        .raddr     (raddr),
        .rpend     (rpend_raw)
    );

    assign rpend = ready ? rpend_raw : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp with two read and two write ports.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int AW    = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NW-1:0]           we;
    logic [NW-1:0][AW-1:0]   waddr;
    logic [NW-1:0][XLEN-1:0] wdata;
    logic [NR-1:0][AW-1:0]   raddr;
    logic [NR-1:0][XLEN-1:0] rdata;
    logic [NR-1:0]           rpend;
    logic                    iss_valid;
    logic [AW-1:0]           iss_addr;
    logic                    flush;
    logic                    ready;

    regfile_mp #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .rpend     (rpend),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = '0;
        iss_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        idle();
        waddr    = '0;
        wdata    = '0;
        raddr    = '0;
        iss_addr = '0;
        #23;
        rst_n    = 1'b1;
        we       = 2'b01;
        waddr[0] = 5;
        wdata[0] = 32'hDEAD;
        raddr[0] = 5;
        raddr[1] = 5;
        for (int c = 0; c <= DEPTH; c++) begin
            if (c == DEPTH) we = '0;
            exp_q.push_back('{$sformatf("ready_cycle%0d", c), XLEN'(c >= DEPTH)});
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (XLEN'(ready) !== e.val) begin
                n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, ready, e.val);
            end
            if (c < DEPTH) begin
                exp_q.push_back('{$sformatf("init_rdata_cycle%0d", c), '0});
                e = exp_q.pop_front(); n_cmp++;
                if (rdata[0] !== e.val) begin
                    n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
                end
            end
            if (c == 0) begin
                exp_q.push_back('{"init_rpend", '0});
                e = exp_q.pop_front(); n_cmp++;
                if (XLEN'(rpend[0]) !== e.val) begin
                    n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[0], e.val);
                end
            end
            if (c < DEPTH) step();
        end
        for (int r = 0; r < DEPTH; r++) begin
            raddr[0] = AW'(r);
            exp_q.push_back('{$sformatf("cleared_reg%0d", r), '0});
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (rdata[0] !== e.val) begin
                n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
            end
        end
    endtask

    task automatic test_bypass();
        step();
        we       = 2'b01;
        waddr[0] = 3;
        wdata[0] = 32'h1234_5678;
        raddr[0] = 3;
        exp_q.push_back('{"bypass_same_cycle", 32'h1234_5678});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
        step();
        idle();
        exp_q.push_back('{"stored_after_write", 32'h1234_5678});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
    endtask

    task automatic test_multi_write();
        step();
        we       = 2'b11;
        waddr[0] = 7;
        waddr[1] = 7;
        wdata[0] = 32'hAAAA;
        wdata[1] = 32'hBBBB;
        raddr[0] = 7;
        raddr[1] = 3;
        exp_q.push_back('{"dual_write_bypass", 32'hBBBB});
        exp_q.push_back('{"other_port_read", 32'h1234_5678});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[1] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[1], e.val);
        end
        step();
        idle();
        exp_q.push_back('{"dual_write_stored", 32'hBBBB});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
        we       = 2'b01;
        waddr[0] = 0;
        wdata[0] = 32'hFFFF;
        raddr[0] = 0;
        exp_q.push_back('{"zero_reg_bypass", '0});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
        step();
        idle();
        exp_q.push_back('{"zero_reg_stored", '0});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
    endtask

    task automatic test_scoreboard();
        step();
        iss_valid = 1'b1;
        iss_addr  = 9;
        raddr[0]  = 9;
        step();
        idle();
        exp_q.push_back('{"pend_after_issue", 32'd1});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[0]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[0], e.val);
        end
        we       = 2'b10;
        waddr[1] = 9;
        wdata[1] = 32'h0000_0999;
        exp_q.push_back('{"pend_during_writeback", '0});
        exp_q.push_back('{"writeback_bypass", 32'h0000_0999});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[0]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[0], e.val);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
        step();
        idle();
        exp_q.push_back('{"pend_after_writeback", '0});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[0]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[0], e.val);
        end
        iss_valid = 1'b1;
        iss_addr  = 9;
        we        = 2'b01;
        waddr[0]  = 9;
        wdata[0]  = 32'h0000_0123;
        step();
        idle();
        exp_q.push_back('{"issue_beats_writeback", 32'd1});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[0]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[0], e.val);
        end
    endtask

    task automatic test_flush();
        int addrs[5] = '{1, 2, 3, 4, 12};
        for (int k = 1; k <= 4; k++) begin
            step();
            iss_valid = 1'b1;
            iss_addr  = AW'(k);
        end
        step();
        iss_valid = 1'b1;
        iss_addr  = 12;
        flush     = 1'b1;
        step();
        idle();
        foreach (addrs[k]) begin
            raddr[0] = AW'(addrs[k]);
            exp_q.push_back('{$sformatf("flush_pend_addr%0d", addrs[k]), XLEN'(addrs[k] == 12)});
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (XLEN'(rpend[0]) !== e.val) begin
                n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[0], e.val);
            end
        end
        raddr[0] = 9;
        exp_q.push_back('{"flush_pend_addr9", '0});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[0]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[0], e.val);
        end
        step();
        iss_valid = 1'b1;
        iss_addr  = 0;
        step();
        idle();
        raddr[0] = 0;
        exp_q.push_back('{"zero_reg_never_pending", '0});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[0]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[0], e.val);
        end
    endtask

    task automatic test_mid_reset();
        int k_ready;
        step();
        we       = 2'b01;
        waddr[0] = 4;
        wdata[0] = 32'h55;
        step();
        idle();
        raddr[0] = 4;
        raddr[1] = 12;
        exp_q.push_back('{"pre_reset_value", 32'h55});
        exp_q.push_back('{"pre_reset_pend12", 32'd1});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[1]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[1], e.val);
        end
        #2;
        rst_n = 1'b0;
        exp_q.push_back('{"async_ready_drop", '0});
        exp_q.push_back('{"async_rpend_drop", '0});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(ready) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, ready, e.val);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[1]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[1], e.val);
        end
        #2;
        rst_n   = 1'b1;
        k_ready = -1;
        for (int k = 1; k <= DEPTH + 8; k++) begin
            step();
            if (ready) begin
                k_ready = k;
                break;
            end
        end
        exp_q.push_back('{"reinit_cycles", XLEN'(DEPTH)});
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(k_ready) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0d, want %0d", e.tag, k_ready, e.val);
        end
        exp_q.push_back('{"reinit_addr4", '0});
        exp_q.push_back('{"reinit_pend12", '0});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata[0] !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rdata[0], e.val);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (XLEN'(rpend[1]) !== e.val) begin
            n_mis++; $display("FAIL %s: got %0h, want %0h", e.tag, rpend[1], e.val);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_multi_write();
        test_scoreboard();
        test_flush();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
